fifo_tx_sched: RTL
==================

# fifo_tx_sched

Read-side scheduler between the asynchronous byte FIFO and the UART transmitter, clocked in the FIFO read (UART) domain. It pops one byte at a time from the FIFO when enabled and hands it to the transmitter over a valid/busy handshake. It enforces a programmable inter-frame gap and detects a transmitter that never starts. It counts successfully sent frames.

## Interface
Parameters:
- DATA_W, 8, FIFO/UART data width
- GAP_W, 8, width of the inter-frame gap setting
- CNT_W, 16, width of the sent-frame counter
- START_TO, 4, cycles allowed for i_tx_busy to rise after o_tx_valid is asserted (≥1)

Ports:
- i_clk  in  1  read/UART domain clock, rising edge
- i_rstn  in  1  reset; one clock; reset is asynchronous and active-low
- i_en  in  1  scheduler enable, level
- i_fifo_empty  in  1  FIFO empty flag (read domain)
- i_fifo_rdata  in  DATA_W  FIFO read data; valid whenever i_fifo_empty=0
- o_fifo_rinc  out  1  FIFO pop strobe, one cycle per byte
- o_tx_data  out  DATA_W  byte to transmitter, held stable from launch until busy seen
- o_tx_valid  out  1  byte available to transmitter
- i_tx_busy  in  1  transmitter serialising a frame
- i_gap_cycles  in  GAP_W  idle cycles inserted after each frame; sampled at frame end
- o_active  out  1  high in every state except IDLE
- o_tx_err  out  1  one-cycle pulse on start timeout
- o_frame_cnt  out  CNT_W  count of completed frames, wraps

## Operation
States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if i_en=1 and i_fifo_empty=0 at the edge:
  - o_tx_data <= i_fifo_rdata
  - o_fifo_rinc <= 1 for exactly one cycle
  - o_tx_valid <= 1
  - timeout counter <= START_TO
  - go to WAIT_BUSY
  - Otherwise stay in IDLE.
- WAIT_BUSY: o_tx_valid held at 1.
  - If i_tx_busy=1: o_tx_valid <= 0, go to WAIT_DONE.
  - Else the timeout counter decrements. On reaching 0: o_tx_valid <= 0, pulse o_tx_err, do not count the frame, go to GAP. The byte is lost.
- WAIT_DONE: wait for i_tx_busy=0.
  - o_frame_cnt <= o_frame_cnt+1 (modulo 2^CNT_W).
  - Load the gap counter with i_gap_cycles.
  - Go to GAP, or straight to IDLE if i_gap_cycles=0.
- GAP: the gap counter decrements each cycle. Leave for IDLE on the cycle it reaches 0. An error-entered GAP uses the i_gap_cycles value sampled at that moment.
- i_en=0 never aborts a frame. It only blocks the IDLE→WAIT_BUSY transition.
- Only one pop is ever outstanding. The minimum of 2 cycles between pops absorbs the FIFO empty-flag update latency.

## Timing
- Reset (async assert) forces all of the following immediately, mid-frame included: state IDLE, o_fifo_rinc=0, o_tx_valid=0, o_tx_data=0, o_active=0, o_tx_err=0, o_frame_cnt=0, all counters 0. Reset deassertion is synchronised externally.
- All outputs are registered. There is no combinational path from input to output.
- Pop latency: o_fifo_rinc and o_tx_valid both rise 1 cycle after the IDLE edge that sees non-empty.
- Start timeout: o_tx_err fires START_TO+1 cycles after o_tx_valid rises if busy never appears.
- Frame-to-frame spacing after busy falls is i_gap_cycles+1 cycles back to IDLE, then 1 cycle to the next o_tx_valid.
- Busy high on the first WAIT_BUSY cycle is accepted (zero-wait handshake).
- If busy is already high when IDLE launches, it is still taken as acceptance.

## Structure
- Shared package uart_fifo_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2, GAP=2'd3)
  - the default DATA_W
- One sub-module, down_cnt: loadable down-counter with a zero flag, parameterised width. It is instantiated twice, for the gap counter and the timeout counter.
- The FSM and output registers live in the top module.

## Test plan
- FIFO holds 0xA5, i_en=1, transmitter raises busy 1 cycle after valid and holds it for 10 cycles, i_gap_cycles=0 -> exactly one o_fifo_rinc pulse, o_tx_data=0xA5, o_frame_cnt=1, back in IDLE.
- 3 bytes 0x01,0x02,0x03 queued, i_gap_cycles=5 -> three pops in order, each o_tx_valid rise 7 cycles after the previous busy fall, o_frame_cnt=3.
- FIFO non-empty, i_tx_busy stuck 0, START_TO=4 -> o_tx_err pulses once 5 cycles after valid, o_frame_cnt unchanged, next byte launched after the gap.
- i_en dropped while in WAIT_DONE with 2 bytes still queued -> current frame counted, no further o_fifo_rinc until i_en=1.
- i_rstn asserted during WAIT_BUSY -> o_tx_valid and o_active fall without a clock, o_frame_cnt=0; after release, resumes from IDLE.
- o_frame_cnt preset near 2^CNT_W-1 (CNT_W=4, 16 frames) -> wraps to 0 on the 16th frame.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the FIFO read-side transmit scheduler.
// Holds the scheduler state encoding and the default data width.
// No logic; imported by the interface and the scheduler top.
package uart_fifo_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_t;

endpackage

// File: rtl/fifo_tx_sched_if.sv
// FIFO read port plus transmitter handshake between scheduler and its neighbours.
// master = scheduler: sees empty/rdata/busy, drives rinc/tx_data/tx_valid.
// slave  = FIFO + transmitter side (used by the bench).
interface fifo_tx_sched_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              i_fifo_empty;
    logic [DATA_W-1:0] i_fifo_rdata;
    logic              o_fifo_rinc;
    logic [DATA_W-1:0] o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_busy;

    modport master (
        input  i_fifo_empty, i_fifo_rdata, i_tx_busy,
        output o_fifo_rinc, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_fifo_empty, i_fifo_rdata, i_tx_busy,
        input  o_fifo_rinc, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/down_cnt.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
// Latency: loaded/decremented value visible one cycle after the strobe.
// Backpressure: none; decrementing at zero holds the count at zero.
// Ports: i_clk, i_rstn (async active-low), i_load/i_load_val, i_dec, o_zero.
module down_cnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign o_zero = (count == '0);

endmodule

// File: rtl/fifo_tx_sched.sv
// Pops one FIFO byte at a time and hands it to the UART transmitter, with inter-frame gap.
// Latency: rinc/tx_valid one cycle after an IDLE edge that sees non-empty; all outputs registered.
// Backpressure: waits on i_tx_busy; start timeout drops the byte and pulses o_tx_err.
// Ports: i_clk, i_rstn, i_en, i_gap_cycles, bus (FIFO read + tx handshake, master side),
//        o_active, o_tx_err, o_frame_cnt.
module fifo_tx_sched
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int GAP_W    = 8,
    parameter int CNT_W    = 16,
    parameter int START_TO = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [GAP_W-1:0] i_gap_cycles,
    fifo_tx_sched_if.master  bus,
    output logic             o_active,
    output logic             o_tx_err,
    output logic [CNT_W-1:0] o_frame_cnt
);

    localparam int              TO_W    = $clog2(START_TO + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(START_TO);

    sched_state_t      state, state_nxt;
    logic              rinc_q, rinc_nxt;
    logic              valid_q, valid_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              err_q, err_nxt;
    logic              active_q;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    logic              to_load, to_dec, to_zero;
    logic              gap_load, gap_dec, gap_zero;
    logic              enter_gap;
    logic [GAP_W-1:0]  gap_load_val;

    // Gap counter holds "remaining gap cycles minus one": GAP exits on the
    // cycle the zero flag is already set, which is the cycle the nominal
    // i_gap_cycles count would reach zero.
    assign gap_load_val = i_gap_cycles - GAP_W'(1);

    down_cnt #(.W(TO_W)) u_to_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (to_load),
        .i_load_val (TO_LOAD),
        .i_dec      (to_dec),
        .o_zero     (to_zero)
    );

    down_cnt #(.W(GAP_W)) u_gap_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (gap_load),
        .i_load_val (gap_load_val),
        .i_dec      (gap_dec),
        .o_zero     (gap_zero)
    );

    always_comb begin
        state_nxt = state;
        rinc_nxt  = 1'b0;
        valid_nxt = valid_q;
        data_nxt  = data_q;
        err_nxt   = 1'b0;
        cnt_nxt   = cnt_q;
        to_load   = 1'b0;
        to_dec    = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        enter_gap = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_en && !bus.i_fifo_empty) begin
                    data_nxt  = bus.i_fifo_rdata;
                    rinc_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                    to_load   = 1'b1;
                    state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Busy wins over an expiring timeout, so the last allowed
                // cycle still accepts the handshake.
                if (bus.i_tx_busy) begin
                    valid_nxt = 1'b0;
                    state_nxt = WAIT_DONE;
                end else if (to_zero) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b1;
                    enter_gap = 1'b1;
                end else begin
                    to_dec = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.i_tx_busy) begin
                    cnt_nxt   = cnt_q + CNT_W'(1);
                    enter_gap = 1'b1;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_nxt = IDLE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A zero gap skips GAP entirely, both after a frame and after a timeout.
        if (enter_gap) begin
            if (i_gap_cycles == '0) begin
                state_nxt = IDLE;
            end else begin
                gap_load  = 1'b1;
                state_nxt = GAP;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            rinc_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            rinc_q   <= rinc_nxt;
            valid_q  <= valid_nxt;
            data_q   <= data_nxt;
            err_q    <= err_nxt;
            active_q <= (state_nxt != IDLE);
            cnt_q    <= cnt_nxt;
        end
    end

    assign bus.o_fifo_rinc = rinc_q;
    assign bus.o_tx_valid  = valid_q;
    assign bus.o_tx_data   = data_q;
    assign o_tx_err        = err_q;
    assign o_active        = active_q;
    assign o_frame_cnt     = cnt_q;

endmodule
